// File: rtl/decode_execute_stage.sv
// Decode + execute stage for the LEGv8 subset of the 64-bit ARMv8 datapath.
// Combinational decode, register read, ALU and branch-target logic; the only
// state is the 32x64 register file, written on the rising clock edge.
module decode_execute_stage #(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32,
  parameter int NREGS     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_LEN-1:0] instr,
  input  logic [WORD-1:0]      pc_in,
  input  logic [WORD-1:0]      write_data,
  output logic [WORD-1:0]      read_data1,
  output logic [WORD-1:0]      read_data2,
  output logic                 reg2_loc,
  output logic                 uncondbranch,
  output logic                 branch,
  output logic                 mem_read,
  output logic                 mem_to_reg,
  output logic                 mem_write,
  output logic                 alu_src,
  output logic                 reg_write,
  output logic [1:0]           alu_op,
  output logic [WORD-1:0]      ext_addr,
  output logic [WORD-1:0]      alu_result,
  output logic                 zero,
  output logic [WORD-1:0]      branch_target
);

  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [5:0]  OP_B    = 6'h05;

  logic [10:0]     opcode;
  logic [4:0]      rn;
  logic [4:0]      rd;
  logic [4:0]      rm_sel;
  logic [WORD-1:0] operand_b;
  logic [WORD-1:0] regs [0:NREGS-1];

  assign opcode = instr[31:21];
  assign rn     = instr[9:5];
  assign rd     = instr[4:0];
  assign rm_sel = reg2_loc ? instr[4:0] : instr[20:16];

  // Control decode and immediate extraction; unknown opcodes yield all-zero controls.
  always_comb begin
    reg2_loc     = 1'b0;
    alu_src      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    branch       = 1'b0;
    uncondbranch = 1'b0;
    alu_op       = 2'b00;
    ext_addr     = '0;
    if (opcode == OP_LDUR) begin
      alu_src    = 1'b1;
      mem_to_reg = 1'b1;
      reg_write  = 1'b1;
      mem_read   = 1'b1;
      ext_addr   = {{(WORD-9){instr[20]}}, instr[20:12]};
    end else if (opcode == OP_STUR) begin
      reg2_loc  = 1'b1;
      alu_src   = 1'b1;
      mem_write = 1'b1;
      ext_addr  = {{(WORD-9){instr[20]}}, instr[20:12]};
    end else if (opcode == OP_ADD || opcode == OP_SUB ||
                 opcode == OP_AND || opcode == OP_ORR) begin
      reg_write = 1'b1;
      alu_op    = 2'b10;
    end else if (instr[31:24] == OP_CBZ) begin
      reg2_loc = 1'b1;
      branch   = 1'b1;
      alu_op   = 2'b01;
      ext_addr = {{(WORD-19){instr[23]}}, instr[23:5]};
    end else if (instr[31:26] == OP_B) begin
      uncondbranch = 1'b1;
      ext_addr     = {{(WORD-26){instr[25]}}, instr[25:0]};
    end else begin
      reg2_loc = 1'b0;
    end
  end

  // Register reads: X31 is hard-wired to zero, no bypass from the pending write.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (rn != 5'd31) begin
      read_data1 = regs[rn];
    end else begin
      read_data1 = '0;
    end
    if (rm_sel != 5'd31) begin
      read_data2 = regs[rm_sel];
    end else begin
      read_data2 = '0;
    end
  end

  assign operand_b = alu_src ? ext_addr : read_data2;

  // ALU: add for memory ops, pass-B for CBZ, opcode-selected function for R-type.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      2'b00: alu_result = read_data1 + operand_b;
      2'b01: alu_result = operand_b;
      2'b10: begin
        case (opcode)
          OP_ADD:  alu_result = read_data1 + operand_b;
          OP_SUB:  alu_result = read_data1 - operand_b;
          OP_AND:  alu_result = read_data1 & operand_b;
          OP_ORR:  alu_result = read_data1 | operand_b;
          default: alu_result = '0;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

  assign zero          = (alu_result == '0);
  assign branch_target = pc_in + {ext_addr[WORD-3:0], 2'b00};

  // Register file: reset loads X[i] = i and beats any coincident write; X31 never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == NREGS - 1) ? '0 : WORD'(i);
      end
    end else if (reg_write && rd != 5'd31) begin
      regs[rd] <= write_data;
    end else begin
      regs[rd] <= regs[rd];
    end
  end

endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed scoreboard bench for decode_execute_stage: expectations are queued
// when a step is driven and popped/compared on the following falling edge.
module tb_decode_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [63:0] pc_in;
  logic [63:0] write_data;
  logic [63:0] read_data1, read_data2, ext_addr, alu_result, branch_target;
  logic        reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write;
  logic        alu_src, reg_write, zero;
  logic [1:0]  alu_op;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb [$];

  localparam int S_RD1 = 0, S_RD2 = 1, S_ALU = 2, S_ZERO = 3,
                 S_EXT = 4, S_TGT = 5, S_CTRL = 6;

  decode_execute_stage dut (
    .clk(clk), .reset(reset), .instr(instr), .pc_in(pc_in),
    .write_data(write_data), .read_data1(read_data1), .read_data2(read_data2),
    .reg2_loc(reg2_loc), .uncondbranch(uncondbranch), .branch(branch),
    .mem_read(mem_read), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op),
    .ext_addr(ext_addr), .alu_result(alu_result), .zero(zero),
    .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      S_RD1:   return read_data1;
      S_RD2:   return read_data2;
      S_ALU:   return alu_result;
      S_ZERO:  return {63'd0, zero};
      S_EXT:   return ext_addr;
      S_TGT:   return branch_target;
      S_CTRL:  return {54'd0, reg2_loc, alu_src, mem_to_reg, reg_write,
                       mem_read, mem_write, branch, uncondbranch, alu_op};
      default: return 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
  endfunction

  // Drive one step just after the rising edge.
  task automatic drive(input logic rst, input logic [31:0] ins,
                       input logic [63:0] pc, input logic [63:0] wd);
    @(posedge clk);
    #1;
    reset      = rst;
    instr      = ins;
    pc_in      = pc;
    write_data = wd;
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  // Pop every queued expectation and compare on the falling edge.
  task automatic check_all();
    exp_t e;
    logic [63:0] o;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      vectors++;
      assert (o === e.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; instr = 32'h0; pc_in = 64'h0; write_data = 64'h0;

    // Reset for one cycle
    drive(1'b1, 32'h0000_0000, 64'h0, 64'h0);
    expect_val("unlisted_ctrl", S_CTRL, 64'h0);
    expect_val("unlisted_ext", S_EXT, 64'h0);
    check_all();

    // ADD X3,X1,X2 with write_data 30
    drive(1'b0, 32'h8B02_0023, 64'h0, 64'd30);
    expect_val("add_rd1", S_RD1, 64'd1);
    expect_val("add_rd2", S_RD2, 64'd2);
    expect_val("add_alu", S_ALU, 64'd3);
    expect_val("add_zero", S_ZERO, 64'd0);
    expect_val("add_ctrl", S_CTRL, 64'h042);
    check_all();

    // ORR X6,X3,X0 sees X3=30
    drive(1'b0, 32'hAA00_0066, 64'h0, 64'd6);
    expect_val("orr_rd1", S_RD1, 64'd30);
    expect_val("orr_alu", S_ALU, 64'd30);
    check_all();

    // SUB X4,X2,X2 -> zero
    drive(1'b0, 32'hCB02_0044, 64'h0, 64'd4);
    expect_val("sub_alu", S_ALU, 64'd0);
    expect_val("sub_zero", S_ZERO, 64'd1);
    check_all();

    // LDUR X5,[X10,#8]
    drive(1'b0, 32'hF840_8145, 64'h0, 64'd5);
    expect_val("ldur_ext", S_EXT, 64'd8);
    expect_val("ldur_ctrl", S_CTRL, 64'h1E0);
    expect_val("ldur_alu", S_ALU, 64'd18);
    check_all();

    // AND X8,X5,X3 = 5 & 30
    drive(1'b0, 32'h8A03_00A8, 64'h0, 64'd8);
    expect_val("and_alu", S_ALU, 64'd4);
    check_all();

    // SUB X7,X0,X1 wraps to all ones
    drive(1'b0, 32'hCB01_0007, 64'h0, 64'd7);
    expect_val("sub_wrap_alu", S_ALU, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_val("sub_wrap_zero", S_ZERO, 64'd0);
    check_all();

    // STUR X1,[X2,#16]
    drive(1'b0, 32'hF801_0041, 64'h0, 64'd99);
    expect_val("stur_ctrl", S_CTRL, 64'h310);
    expect_val("stur_ext", S_EXT, 64'd16);
    expect_val("stur_rd2", S_RD2, 64'd1);
    expect_val("stur_alu", S_ALU, 64'd18);
    check_all();

    // CBZ X0,#-2 at 0x40
    drive(1'b0, 32'hB4FF_FFC0, 64'h40, 64'd99);
    expect_val("cbz_rd2", S_RD2, 64'd0);
    expect_val("cbz_zero", S_ZERO, 64'd1);
    expect_val("cbz_ctrl", S_CTRL, 64'h209);
    expect_val("cbz_ext", S_EXT, 64'hFFFF_FFFF_FFFF_FFFE);
    expect_val("cbz_target", S_TGT, 64'h38);
    check_all();

    // B #4 at 0x10
    drive(1'b0, 32'h1400_0004, 64'h10, 64'd99);
    expect_val("b_ctrl", S_CTRL, 64'h004);
    expect_val("b_ext", S_EXT, 64'd4);
    expect_val("b_target", S_TGT, 64'h20);
    check_all();

    // ADD X9,X9,X0 writing 50: same-cycle read still shows old X9
    drive(1'b0, 32'h8B00_0129, 64'h0, 64'd50);
    expect_val("nobypass_rd1", S_RD1, 64'd9);
    check_all();

    // ORR X6,X9,X0 now shows 50
    drive(1'b0, 32'hAA00_0126, 64'h0, 64'd6);
    expect_val("write_vis_rd1", S_RD1, 64'd50);
    check_all();

    // ADD X31,X1,X2 with write_data 14 (discarded)
    drive(1'b0, 32'h8B02_003F, 64'h0, 64'd14);
    expect_val("x31w_alu", S_ALU, 64'd3);
    check_all();

    // ORR X6,X31,X0: X31 still reads 0
    drive(1'b0, 32'hAA00_03E6, 64'h0, 64'd6);
    expect_val("x31_rd1", S_RD1, 64'd0);
    expect_val("x31_zero", S_ZERO, 64'd1);
    check_all();

    // Reset with a coincident ADD X3 write of 99: reset wins
    drive(1'b1, 32'h8B02_0023, 64'h0, 64'd99);
    check_all();

    // ORR X6,X3,X0 after reset: X3 back to 3, X9 back to 9
    drive(1'b0, 32'hAA00_0066, 64'h0, 64'd6);
    expect_val("rst_x3_rd1", S_RD1, 64'd3);
    expect_val("rst_x3_alu", S_ALU, 64'd3);
    check_all();

    drive(1'b0, 32'hAA00_0126, 64'h0, 64'd6);
    expect_val("rst_x9_rd1", S_RD1, 64'd9);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
